// File: rtl/pkg_en.sv
// Shared widths and token types for the external-memory streaming ports.
package pkg_en;

  localparam int WIDTH_EXADDR = 32;
  localparam int WIDTH_DATA   = 32;
  localparam int EXT_LEN_W    = 16;

  typedef struct packed {
    logic                  v;
    logic                  a;
    logic                  r;
    logic                  c;
    logic [EXT_LEN_W-1:0]  i;
    logic [WIDTH_DATA-1:0] d;
  } FTk_t;

  typedef struct packed {
    logic n;
  } BTk_t;

  typedef enum logic [1:0] {LD_IDLE, LD_ISSUE, LD_DRAIN} ld_state_e;
  typedef enum logic       {ST_IDLE, ST_RUN} st_state_e;

endpackage

// File: rtl/ext_ld_fifo.sv
// Return-data FIFO for the load channel; storage is not reset, only pointers and count.
module ext_ld_fifo
  import pkg_en::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        push,
  input  FTk_t        push_data,
  input  logic        pop,
  output FTk_t        head,
  output logic        full,
  output logic        empty,
  output logic [AW:0] count
);

  FTk_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ext_mem_stream_port.sv
// Strided load/store streaming between fabric tokens and an external memory port.
// ld: IDLE | no descriptor ; ISSUE | issuing reads ; DRAIN | all issued, emptying FIFO
// st: IDLE | fabric stalled ; RUN | forwarding words to memory
module ext_mem_stream_port
  import pkg_en::*;
#(
  parameter int LD_FIFO_DEPTH = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    I_Ld_Start,
  input  logic [WIDTH_EXADDR-1:0] I_Ld_Base,
  input  logic [EXT_LEN_W-1:0]    I_Ld_Len,
  input  logic [WIDTH_EXADDR-1:0] I_Ld_Stride,
  output logic                    O_Ld_Req,
  output logic [WIDTH_EXADDR-1:0] O_Ld_Addr,
  input  FTk_t                    I_Ld_FTk,
  output BTk_t                    O_Ld_BTk,
  output FTk_t                    O_Ld_FTk,
  input  BTk_t                    I_Ld_BTk,
  input  logic                    I_St_Start,
  input  logic [WIDTH_EXADDR-1:0] I_St_Base,
  input  logic [EXT_LEN_W-1:0]    I_St_Len,
  input  logic [WIDTH_EXADDR-1:0] I_St_Stride,
  input  FTk_t                    I_St_FTk,
  output BTk_t                    O_St_BTk,
  output logic                    O_St_Req,
  output logic [WIDTH_EXADDR-1:0] O_St_Addr,
  output FTk_t                    O_St_FTk,
  input  BTk_t                    I_St_BTk,
  output logic                    O_Ld_Busy,
  output logic                    O_St_Busy
);

  localparam int CW = $clog2(LD_FIFO_DEPTH);

  ld_state_e               ld_state, ld_state_nxt;
  logic [WIDTH_EXADDR-1:0] ld_addr, ld_stride;
  logic [EXT_LEN_W-1:0]    ld_len, ld_left, ld_ret_idx;
  logic                    ld_inflight, ld_start_ok, ld_room, ld_push, ld_pop;
  logic                    ld_full, ld_empty;
  logic [CW:0]             ld_count;
  FTk_t                    ld_push_data, ld_head;

  st_state_e               st_state, st_state_nxt;
  logic [WIDTH_EXADDR-1:0] st_addr, st_stride;
  logic [EXT_LEN_W-1:0]    st_left;
  logic                    st_start_ok, st_accept;

  logic                    unused_ok;

  // Room counts words already buffered plus the one read still returning.
  assign ld_room     = ({1'b0, ld_count} + (CW+2)'(ld_inflight)) < (CW+2)'(LD_FIFO_DEPTH);
  assign ld_start_ok = (ld_state == LD_IDLE) && I_Ld_Start && (I_Ld_Len != '0);
  assign ld_push     = ld_inflight && I_Ld_FTk.v;
  assign ld_pop      = !ld_empty && !I_Ld_BTk.n;
  assign O_Ld_Addr   = ld_addr;
  assign O_Ld_FTk    = ld_empty ? '0 : ld_head;
  assign O_Ld_BTk    = '0;
  assign O_Ld_Busy   = (ld_state != LD_IDLE);
  assign unused_ok   = ^{ld_full, I_Ld_FTk.a, I_Ld_FTk.r, I_Ld_FTk.c, I_Ld_FTk.i};

  always_comb begin
    ld_push_data   = '0;
    ld_push_data.v = 1'b1;
    ld_push_data.a = (ld_ret_idx == '0);
    ld_push_data.r = (ld_ret_idx == ld_len - EXT_LEN_W'(1));
    ld_push_data.i = ld_ret_idx;
    ld_push_data.d = I_Ld_FTk.d;
  end

  ext_ld_fifo #(.DEPTH(LD_FIFO_DEPTH)) u_ld_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (ld_push),
    .push_data (ld_push_data),
    .pop       (ld_pop),
    .head      (ld_head),
    .full      (ld_full),
    .empty     (ld_empty),
    .count     (ld_count)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      ld_state    <= LD_IDLE;
      ld_inflight <= 1'b0;
      ld_addr     <= '0;
      ld_stride   <= '0;
      ld_len      <= '0;
      ld_left     <= '0;
      ld_ret_idx  <= '0;
    end else begin
      ld_state    <= ld_state_nxt;
      ld_inflight <= O_Ld_Req;
      if (ld_start_ok) begin
        ld_addr    <= I_Ld_Base;
        ld_stride  <= I_Ld_Stride;
        ld_len     <= I_Ld_Len;
        ld_left    <= I_Ld_Len;
        ld_ret_idx <= '0;
      end else begin
        if (O_Ld_Req) begin
          ld_addr <= ld_addr + ld_stride;
          ld_left <= ld_left - EXT_LEN_W'(1);
        end
        if (ld_push) ld_ret_idx <= ld_ret_idx + EXT_LEN_W'(1);
      end
    end
  end

  always_comb begin
    ld_state_nxt = ld_state;
    O_Ld_Req     = 1'b0;
    case (ld_state)
      LD_IDLE:  if (ld_start_ok) ld_state_nxt = LD_ISSUE;
      LD_ISSUE: begin
        O_Ld_Req = ld_room;
        if (ld_room && ld_left == EXT_LEN_W'(1)) ld_state_nxt = LD_DRAIN;
      end
      LD_DRAIN: begin
        // Leave on the edge that hands over the final word.
        if (!ld_inflight && (ld_empty || (ld_count == (CW+1)'(1) && ld_pop)))
          ld_state_nxt = LD_IDLE;
      end
      default:  ld_state_nxt = LD_IDLE;
    endcase
  end

  assign st_start_ok = (st_state == ST_IDLE) && I_St_Start && (I_St_Len != '0);
  assign st_accept   = (st_state == ST_RUN) && I_St_FTk.v && !I_St_BTk.n;
  assign O_St_Addr   = st_addr;
  assign O_St_Busy   = (st_state != ST_IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      st_state  <= ST_IDLE;
      st_addr   <= '0;
      st_stride <= '0;
      st_left   <= '0;
    end else begin
      st_state <= st_state_nxt;
      if (st_start_ok) begin
        st_addr   <= I_St_Base;
        st_stride <= I_St_Stride;
        st_left   <= I_St_Len;
      end else if (st_accept) begin
        st_addr <= st_addr + st_stride;
        st_left <= st_left - EXT_LEN_W'(1);
      end
    end
  end

  always_comb begin
    st_state_nxt = st_state;
    O_St_Req     = 1'b0;
    O_St_FTk     = '0;
    O_St_BTk.n   = 1'b1;
    case (st_state)
      ST_IDLE: if (st_start_ok) st_state_nxt = ST_RUN;
      ST_RUN: begin
        O_St_FTk   = I_St_FTk;
        O_St_Req   = I_St_FTk.v;
        O_St_BTk.n = I_St_BTk.n;
        if (st_accept && st_left == EXT_LEN_W'(1)) st_state_nxt = ST_IDLE;
      end
      default: st_state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ext_mem_stream_port.sv
// Randomised bench for ext_mem_stream_port against a queue-based transfer model.
module tb_ext_mem_stream_port;
  import pkg_en::*;

  localparam int DEPTH = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic I_Ld_Start = 0, I_St_Start = 0;
  logic [31:0] I_Ld_Base = 0, I_Ld_Stride = 0, I_St_Base = 0, I_St_Stride = 0;
  logic [15:0] I_Ld_Len = 0, I_St_Len = 0;
  FTk_t I_Ld_FTk = '0, I_St_FTk = '0;
  BTk_t I_Ld_BTk = '0, I_St_BTk = '0;
  logic O_Ld_Req, O_St_Req, O_Ld_Busy, O_St_Busy;
  logic [31:0] O_Ld_Addr, O_St_Addr;
  FTk_t O_Ld_FTk, O_St_FTk;
  BTk_t O_Ld_BTk, O_St_BTk;

  ext_mem_stream_port #(.LD_FIFO_DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .I_Ld_Start(I_Ld_Start), .I_Ld_Base(I_Ld_Base), .I_Ld_Len(I_Ld_Len), .I_Ld_Stride(I_Ld_Stride),
    .O_Ld_Req(O_Ld_Req), .O_Ld_Addr(O_Ld_Addr), .I_Ld_FTk(I_Ld_FTk), .O_Ld_BTk(O_Ld_BTk),
    .O_Ld_FTk(O_Ld_FTk), .I_Ld_BTk(I_Ld_BTk),
    .I_St_Start(I_St_Start), .I_St_Base(I_St_Base), .I_St_Len(I_St_Len), .I_St_Stride(I_St_Stride),
    .I_St_FTk(I_St_FTk), .O_St_BTk(O_St_BTk),
    .O_St_Req(O_St_Req), .O_St_Addr(O_St_Addr), .O_St_FTk(O_St_FTk), .I_St_BTk(I_St_BTk),
    .O_Ld_Busy(O_Ld_Busy), .O_St_Busy(O_St_Busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp_v);
    end
  endtask

  // memory contents: explicit words where preset, otherwise a fixed hash of the address
  logic [31:0] mem_pre [logic [31:0]];
  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem_pre.exists(a)) return mem_pre[a];
    return {a[15:0] ^ 16'h5A3C, a[31:16]};
  endfunction
  logic [31:0] wmem [logic [31:0]];
  int          wcnt [logic [31:0]];

  // behavioural model state
  bit          ld_active = 0, st_active = 0, rst_seen = 0;
  logic [31:0] ld_iss_q[$];
  FTk_t        ld_exp_q[$];
  int          ld_out = 0, ld_out_max = 0;
  logic [31:0] st_exp_a[$], st_exp_d[$];
  logic [31:0] st_words [16];
  logic [31:0] ld_addr_log[$];
  FTk_t        ld_log[$];
  int          st_wr_cnt = 0, y_present = 0;
  logic [31:0] y_val = 0;

  // stimulus agents
  FTk_t        st_src_q[$];
  bit          src_acc = 0, st_src_rand = 0, ld_n_rand = 0, stalled_once = 0;
  int          st_mem_mode = 0, cyc = 0, win_lo = 1, win_hi = 0;
  logic        mem_req_s = 0;
  logic [31:0] mem_addr_s = 0;

  always @(negedge clock) begin : cmp
    bit          exp_req, ld_go, st_go;
    logic [31:0] a;
    FTk_t        e;
    if (reset) begin
      ld_active = 0; st_active = 0; rst_seen = 1;
      ld_iss_q.delete(); ld_exp_q.delete(); ld_out = 0;
      st_exp_a.delete(); st_exp_d.delete();
      src_acc = 0;
    end else begin
      if (rst_seen) begin
        chk("rst_ld_req", O_Ld_Req, 0);
        chk("rst_ld_ftk", O_Ld_FTk, 0);
        chk("rst_st_v", O_St_FTk.v, 0);
        chk("rst_st_n", O_St_BTk.n, 1);
        chk("rst_busy", {O_Ld_Busy, O_St_Busy}, 0);
        rst_seen = 0;
      end
      chk("ld_busy", O_Ld_Busy, ld_active);
      chk("st_busy", O_St_Busy, st_active);
      chk("ld_btk", O_Ld_BTk, 0);
      exp_req = ld_active && ld_iss_q.size() > 0 && ld_out < DEPTH;
      chk("ld_req", O_Ld_Req, exp_req);
      if (O_Ld_Req && ld_iss_q.size() > 0) chk("ld_addr", O_Ld_Addr, ld_iss_q[0]);
      if (O_Ld_FTk.v) begin
        if (ld_exp_q.size() == 0) chk("ld_spurious_v", O_Ld_FTk.v, 0);
        else chk("ld_tok", O_Ld_FTk, ld_exp_q[0]);
      end
      chk("st_req", O_St_Req, st_active && I_St_FTk.v);
      if (O_St_Req) begin
        chk("st_ftk", O_St_FTk, I_St_FTk);
        if (st_exp_a.size() > 0) chk("st_addr", O_St_Addr, st_exp_a[0]);
      end
      chk("st_btk_n", O_St_BTk.n, st_active ? I_St_BTk.n : 1'b1);

      ld_go = I_Ld_Start && !ld_active && I_Ld_Len != 0;
      st_go = I_St_Start && !st_active && I_St_Len != 0;
      if (O_Ld_Req && ld_iss_q.size() > 0) begin
        ld_addr_log.push_back(ld_iss_q.pop_front());
        ld_out++;
        if (ld_out > ld_out_max) ld_out_max = ld_out;
      end
      if (O_Ld_FTk.v && !I_Ld_BTk.n && ld_exp_q.size() > 0) begin
        ld_log.push_back(O_Ld_FTk);
        void'(ld_exp_q.pop_front());
        ld_out--;
        if (ld_exp_q.size() == 0 && ld_iss_q.size() == 0) ld_active = 0;
      end
      if (ld_go) begin
        ld_active = 1;
        for (int k = 0; k < int'(I_Ld_Len); k++) begin
          a = I_Ld_Base + 32'(k) * I_Ld_Stride;
          ld_iss_q.push_back(a);
          e = '0; e.v = 1; e.a = (k == 0); e.r = (k == int'(I_Ld_Len) - 1);
          e.i = 16'(k); e.d = mem_rd(a);
          ld_exp_q.push_back(e);
        end
      end
      if (O_St_Req && O_St_FTk.d == y_val) y_present++;
      if (O_St_Req && !I_St_BTk.n) begin
        wmem[O_St_Addr] = O_St_FTk.d;
        wcnt[O_St_Addr] = wcnt.exists(O_St_Addr) ? wcnt[O_St_Addr] + 1 : 1;
        st_wr_cnt++;
        if (st_exp_d.size() > 0) begin
          chk("st_wdata", O_St_FTk.d, st_exp_d[0]);
          void'(st_exp_a.pop_front());
          void'(st_exp_d.pop_front());
          if (st_exp_d.size() == 0) st_active = 0;
        end else chk("st_extra_write", O_St_Req, 0);
      end
      if (st_go) begin
        st_active = 1;
        for (int k = 0; k < int'(I_St_Len); k++) begin
          st_exp_a.push_back(I_St_Base + 32'(k) * I_St_Stride);
          st_exp_d.push_back(st_words[k]);
        end
      end
      src_acc = I_St_FTk.v && !O_St_BTk.n;
    end
    mem_req_s  = O_Ld_Req;
    mem_addr_s = O_Ld_Addr;
  end

  always @(posedge clock) begin : agents
    cyc++;
    #1;
    I_Ld_FTk   = '0;
    I_Ld_FTk.v = mem_req_s;
    I_Ld_FTk.d = mem_rd(mem_addr_s);
    I_Ld_BTk.n = (cyc >= win_lo && cyc <= win_hi) || (ld_n_rand && $urandom_range(2) == 0);
    if (src_acc && st_src_q.size() > 0) void'(st_src_q.pop_front());
    src_acc = 0;
    if (st_src_q.size() > 0 && (!st_src_rand || $urandom_range(3) != 0)) I_St_FTk = st_src_q[0];
    else I_St_FTk = '0;
    #1;
    case (st_mem_mode)
      1: I_St_BTk.n = ($urandom_range(2) == 0);
      2: begin
        I_St_BTk.n = O_St_Req && st_wr_cnt == 1 && !stalled_once;
        if (I_St_BTk.n) stalled_once = 1;
      end
      default: I_St_BTk.n = 1'b0;
    endcase
  end

  task automatic pulse(input bit lg, input logic [31:0] lb, input logic [15:0] ll, input logic [31:0] ls,
                       input bit sg, input logic [31:0] sb, input logic [15:0] sl, input logic [31:0] ss);
    @(posedge clock); #1;
    I_Ld_Start = lg; I_Ld_Base = lb; I_Ld_Len = ll; I_Ld_Stride = ls;
    I_St_Start = sg; I_St_Base = sb; I_St_Len = sl; I_St_Stride = ss;
    if (sg && !st_active)
      for (int k = 0; k < int'(sl); k++) begin
        FTk_t w;
        w = '0; w.v = 1; w.i = 16'(k); w.a = (k == 0); w.d = st_words[k];
        st_src_q.push_back(w);
      end
    @(posedge clock); #1;
    I_Ld_Start = 0; I_St_Start = 0;
  endtask

  task automatic wait_idle(input string nm, input int budget);
    int n = 0;
    while ((ld_active || st_active) && n < budget) begin
      @(negedge clock);
      n++;
    end
    if (n >= budget) begin
      checks++; errors++;
      $display("FAIL %s_timeout: still busy after %0d cycles, required idle", nm, n);
    end
    repeat (2) @(negedge clock);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int a0, l0, n;
    repeat (3) @(posedge clock);
    #1 reset = 0;

    // load Base=0x10 Len=4 Stride=1 with known memory words
    mem_pre[32'h10] = 32'hAAAA_0001; mem_pre[32'h11] = 32'hBBBB_0002;
    mem_pre[32'h12] = 32'hCCCC_0003; mem_pre[32'h13] = 32'hDDDD_0004;
    a0 = ld_addr_log.size(); l0 = ld_log.size();
    pulse(1, 32'h10, 4, 1, 0, 0, 0, 0);
    wait_idle("ld_basic", 200);
    chk("t1_addr0", ld_addr_log[a0], 32'h10);
    chk("t1_addr3", ld_addr_log[a0+3], 32'h13);
    chk("t1_d0", ld_log[l0].d, 32'hAAAA_0001);
    chk("t1_a0", ld_log[l0].a, 1);
    chk("t1_a1", ld_log[l0+1].a, 0);
    chk("t1_d3", ld_log[l0+3].d, 32'hDDDD_0004);
    chk("t1_r3", ld_log[l0+3].r, 1);
    chk("t1_busy", O_Ld_Busy, 0);

    // same load with fabric back-pressure shortly after start
    l0 = ld_log.size(); ld_out_max = 0;
    pulse(1, 32'h10, 4, 1, 0, 0, 0, 0);
    win_lo = cyc + 1; win_hi = cyc + 5;
    wait_idle("ld_bp", 200);
    chk("t2_outstanding_max", ld_out_max, 4);
    chk("t2_d0", ld_log[l0].d, 32'hAAAA_0001);
    chk("t2_d1", ld_log[l0+1].d, 32'hBBBB_0002);
    chk("t2_d2", ld_log[l0+2].d, 32'hCCCC_0003);
    chk("t2_d3", ld_log[l0+3].d, 32'hDDDD_0004);

    // store X,Y,Z to 0x20 stride 2 with one memory stall on Y
    st_words[0] = 32'h1111_AAAA; st_words[1] = 32'h2222_BBBB; st_words[2] = 32'h3333_CCCC;
    y_val = 32'h2222_BBBB; y_present = 0; st_wr_cnt = 0; stalled_once = 0; st_mem_mode = 2;
    pulse(0, 0, 0, 0, 1, 32'h20, 3, 2);
    wait_idle("st_basic", 200);
    y_val = 0; st_mem_mode = 0;
    chk("t3_m20", wmem[32'h20], 32'h1111_AAAA);
    chk("t3_m22", wmem[32'h22], 32'h2222_BBBB);
    chk("t3_m24", wmem[32'h24], 32'h3333_CCCC);
    chk("t3_y_writes", wcnt[32'h22], 1);
    chk("t3_y_presented", y_present, 2);

    // address wrap at top of space
    a0 = ld_addr_log.size();
    pulse(1, 32'hFFFF_FFFE, 3, 1, 0, 0, 0, 0);
    wait_idle("ld_wrap", 200);
    chk("t4_addr1", ld_addr_log[a0+1], 32'hFFFF_FFFF);
    chk("t4_addr2", ld_addr_log[a0+2], 32'h0);

    // zero-length descriptors are ignored
    pulse(1, 32'h40, 0, 1, 1, 32'h40, 0, 1);
    repeat (2) @(negedge clock);
    chk("t4_len0_busy", {O_Ld_Busy, O_St_Busy}, 0);

    // reset in the middle of a load, then restart
    l0 = ld_log.size();
    pulse(1, 32'h100, 8, 1, 0, 0, 0, 0);
    n = 0;
    while (ld_log.size() < l0 + 2 && n < 300) begin @(negedge clock); n++; end
    if (n >= 300) begin checks++; errors++; $display("FAIL t5_two_words: got %0d words, required 2", ld_log.size() - l0); end
    @(posedge clock); #1 reset = 1;
    @(posedge clock); #1 reset = 0;
    repeat (3) @(negedge clock);
    l0 = ld_log.size();
    pulse(1, 32'h200, 2, 1, 0, 0, 0, 0);
    wait_idle("ld_restart", 200);
    chk("t5_count", ld_log.size() - l0, 2);
    chk("t5_i0", ld_log[l0].i, 0);
    chk("t5_a0", ld_log[l0].a, 1);
    chk("t5_d0", ld_log[l0].d, mem_rd(32'h200));

    // concurrent load and store with extra starts while busy
    for (int k = 0; k < 16; k++) st_words[k] = $urandom;
    l0 = ld_log.size(); st_wr_cnt = 0; ld_n_rand = 1; st_mem_mode = 1;
    pulse(1, 32'h300, 4, 4, 1, 32'h400, 4, 4);
    pulse(1, 32'h500, 6, 1, 1, 32'h600, 6, 1);
    wait_idle("concurrent", 400);
    chk("t6_ld_count", ld_log.size() - l0, 4);
    chk("t6_st_count", st_wr_cnt, 4);

    // randomised descriptors and handshakes
    for (int it = 0; it < 25; it++) begin
      bit lg, sg;
      for (int k = 0; k < 16; k++) st_words[k] = $urandom;
      lg = $urandom_range(1); sg = $urandom_range(1) || !lg;
      ld_n_rand = $urandom_range(1); st_mem_mode = $urandom_range(1); st_src_rand = $urandom_range(1);
      pulse(lg, $urandom, 16'($urandom_range(10)), 32'($urandom_range(7)),
            sg, $urandom, 16'($urandom_range(10)), 32'($urandom_range(7)));
      if ($urandom_range(1)) pulse(1, $urandom, 16'($urandom_range(1, 10)), 1, 1, $urandom, 16'($urandom_range(1, 10)), 1);
      wait_idle("random", 600);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ext_mem_stream_port.md
EXT_MEM_STREAM_PORT -- requirements
Module: ext_mem_stream_port

Interface
REQ-001 SHALL have parameter LD_FIFO_DEPTH, default 4, meaning return-data FIFO entries (power of two, >=2).
REQ-002 SHALL have ports, in order: clock  in  1  single clock; reset  in  1  synchronous active-high reset.
REQ-003 SHALL have I_Ld_Start  in  1  one-cycle pulse that latches the load descriptor.
REQ-004 SHALL have I_Ld_Base  in  WIDTH_EXADDR  load base address; I_Ld_Len  in  EXT_LEN_W  load word count; I_Ld_Stride  in  WIDTH_EXADDR  load address increment.
REQ-005 SHALL have O_Ld_Req  out  1  memory read request; O_Ld_Addr  out  WIDTH_EXADDR  read address; I_Ld_FTk  in  FTk_t  memory return token; O_Ld_BTk  out  BTk_t  back token to memory (always '0).
REQ-006 SHALL have O_Ld_FTk  out  FTk_t  load stream to fabric; I_Ld_BTk  in  BTk_t  fabric back token (n = nack).
REQ-007 SHALL have I_St_Start, I_St_Base, I_St_Len, I_St_Stride  in  1/WIDTH_EXADDR/EXT_LEN_W/WIDTH_EXADDR  store descriptor.
REQ-008 SHALL have I_St_FTk  in  FTk_t  store stream from fabric; O_St_BTk  out  BTk_t  back token to fabric.
REQ-009 SHALL have O_St_Req  out  1; O_St_Addr  out  WIDTH_EXADDR; O_St_FTk  out  FTk_t; I_St_BTk  in  BTk_t  memory write port.
REQ-010 SHALL have O_Ld_Busy, O_St_Busy  out  1  channel active.

Function
REQ-011 Load FSM SHALL have states IDLE, ISSUE, DRAIN; I_Ld_Start in IDLE with I_Ld_Len>0 -> ISSUE; Len=0 ignored; Start outside IDLE ignored.
REQ-012 In ISSUE, O_Ld_Req SHALL assert only when FIFO occupancy + in-flight requests < LD_FIFO_DEPTH; address = Base + k*Stride, k=0..Len-1, modulo 2^WIDTH_EXADDR.
REQ-013 Memory return SHALL be taken as fixed latency 1: the I_Ld_FTk with v=1 in cycle t+1 answers the request of cycle t and is pushed to FIFO.
REQ-014 After last request issued -> DRAIN; DRAIN -> IDLE when FIFO empty, no request in flight and last word accepted.
REQ-015 O_Ld_FTk SHALL present FIFO head with v=1; a=1 on word 0 only, r=1 on word Len-1 only, c=0, d=memory data, i=word index.
REQ-016 Head SHALL pop when v=1 and I_Ld_BTk.n=0; when n=1 token held unchanged; no word dropped or duplicated.
REQ-017 Store FSM SHALL have states IDLE, RUN; I_St_Start with Len>0 -> RUN.
REQ-018 In RUN, O_St_FTk = I_St_FTk, O_St_Req = I_St_FTk.v, O_St_Addr = Base + k*Stride; k advances when v=1 and I_St_BTk.n=0.
REQ-019 O_St_BTk.n SHALL equal I_St_BTk.n in RUN and 1 in IDLE (fabric stalled without descriptor).
REQ-020 RUN -> IDLE in the cycle word Len-1 is accepted; O_St_Req deasserts next cycle.
REQ-021 Load and store channels SHALL operate concurrently and independently.
REQ-022 Busy flags SHALL be 1 in every non-IDLE state.

Reset
REQ-023 On reset both FSMs SHALL go IDLE, FIFO and counters clear; O_Ld_Req=0, O_St_Req=0, O_Ld_FTk='0, O_St_FTk.v=0, O_Ld_BTk='0, O_St_BTk.n=1, Busy=0 next cycle.
REQ-024 Reset mid-transfer SHALL abandon it; memory returns arriving the cycle after reset SHALL be discarded.

Structure
REQ-025 EXT_LEN_W (16) SHALL be added to pkg_en; FTk_t, BTk_t, WIDTH_EXADDR, WIDTH_DATA SHALL come from pkg_en.
REQ-026 Return buffer SHALL be sub-module ext_ld_fifo (FTk_t entries, push/pop/full/empty/count).

Verification
REQ-027 Load Base=0x10, Len=4, Stride=1, n=0, mem[0x10..0x13]=A..D -> Ld_Addr 0x10..0x13, stream A,B,C,D, a on A, r on D, Busy low after drain.
REQ-028 Same load with I_Ld_BTk.n=1 cycles 2-6 -> O_Ld_Req stops at 4 in-flight/buffered, output held, order A..D intact.
REQ-029 Store Base=0x20, Len=3, Stride=2, data X,Y,Z, I_St_BTk.n=1 on 2nd word once -> mem[0x20]=X, [0x22]=Y, [0x24]=Z, Y presented twice, written once.
REQ-030 Load Base=0xFFFF_FFFE-aligned top of space, Len=3, Stride=1 -> third address wraps to 0.
REQ-031 Reset asserted mid-load after 2 words -> outputs per REQ-023, later Start with Len=2 restarts at word 0 with a=1.
REQ-032 Concurrent load Len=4 and store Len=4 plus Start pulses while busy -> both complete, extra Starts ignored.
